// File: rtl/uart_pkg.sv
`timescale 1ns / 1ps
// Shared UART definitions: receiver state encoding and default frame geometry.
package uart_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        BREAK_WAIT = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_sync_edge.sv
`timescale 1ns / 1ps
// Two-flop synchronizer for an asynchronous level, with an optional registered
// rising-edge pulse taken from the synchronized value.
module uart_sync_edge #(
    parameter logic RESET_VAL = 1'b0,
    parameter bit   EDGE_EN   = 1'b0
) (
    input  logic clock,
    input  logic resetn,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_s1 <= RESET_VAL;
            r_s2 <= RESET_VAL;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
        end
    end

    assign o_sync = r_s2;

    generate
        if (EDGE_EN) begin : g_edge
            logic r_s3;
            logic r_rise;

            // Pulse lands three clocks after the raw edge.
            always_ff @(posedge clock) begin
                if (!resetn) begin
                    r_s3   <= RESET_VAL;
                    r_rise <= 1'b0;
                end else begin
                    r_s3   <= r_s2;
                    r_rise <= r_s2 & ~r_s3;
                end
            end

            assign o_rise = r_rise;
        end else begin : g_no_edge
            assign o_rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/uart_receiver.sv
`timescale 1ns / 1ps
// 8N1-style UART receiver: oversampled start validation, centre-sampled LSB-first
// data, stop-bit check with break hold-off, one-cycle valid/error pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  os_clk,
    input  logic                  Rx_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_error,
    output logic                  rx_busy
);

    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W = $clog2(DATA_WIDTH) + 1;

    localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    logic w_rx_s;
    logic w_tick;
    logic w_rx_rise_unused;
    logic w_os_sync_unused;

    rx_state_e             r_state;
    logic [OS_W-1:0]       r_os_cnt;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_ferr;
    logic                  r_busy;

    uart_sync_edge #(
        .RESET_VAL (1'b1),
        .EDGE_EN   (1'b0)
    ) u_rx_sync (
        .clock   (clock),
        .resetn  (resetn),
        .i_async (Rx_in),
        .o_sync  (w_rx_s),
        .o_rise  (w_rx_rise_unused)
    );

    uart_sync_edge #(
        .RESET_VAL (1'b0),
        .EDGE_EN   (1'b1)
    ) u_os_sync (
        .clock   (clock),
        .resetn  (resetn),
        .i_async (os_clk),
        .o_sync  (w_os_sync_unused),
        .o_rise  (w_tick)
    );

    // Frame FSM; rx_busy is tracked alongside every transition into or out of IDLE.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_os_cnt  <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_os_cnt <= '0;
                        r_state  <= START;
                        r_busy   <= 1'b1;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_os_cnt == OS_MID) begin
                            if (!w_rx_s) begin
                                r_os_cnt  <= '0;
                                r_bit_idx <= '0;
                                r_state   <= DATA;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + OS_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_os_cnt == OS_LAST) begin
                            // LSB arrives first, so new bits enter at the top.
                            r_shift   <= {w_rx_s, r_shift[DATA_WIDTH-1:1]};
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                            r_os_cnt  <= '0;
                            if (r_bit_idx == IDX_LAST) begin
                                r_state <= STOP;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + OS_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_os_cnt == OS_LAST) begin
                            r_os_cnt <= '0;
                            if (w_rx_s) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_ferr  <= 1'b1;
                                r_state <= BREAK_WAIT;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + OS_W'(1);
                        end
                    end
                end
                BREAK_WAIT: begin
                    if (w_rx_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out    = r_data;
    assign data_valid  = r_valid;
    assign frame_error = r_ferr;
    assign rx_busy     = r_busy;

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns / 1ps
// Bench for uart_receiver: drives serial frames against a queue-based model of
// the bytes that must appear, plus counters for pulse-shape rules.
module tb_uart_receiver;

    localparam int unsigned DW = 8;
    localparam int unsigned OS = 16;
    // 1 Mbaud keeps the run short while leaving 6+ clocks per oversample edge.
    localparam real BIT_NS      = 1000.0;
    localparam real OS_HALF_NOM = BIT_NS / (2.0 * OS);

    logic          clock  = 1'b0;
    logic          resetn = 1'b0;
    logic          os_clk = 1'b0;
    logic          Rx_in  = 1'b1;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          frame_error;
    logic          rx_busy;

    real os_half_ns = OS_HALF_NOM;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    int fe_cnt     = 0;
    int busy_viol  = 0;
    int long_pulse = 0;
    int both_cnt   = 0;
    logic prev_valid = 1'b0;
    logic prev_fe    = 1'b0;

    uart_receiver #(
        .DATA_WIDTH (DW),
        .OVERSAMPLE (OS)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .os_clk      (os_clk),
        .Rx_in       (Rx_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .rx_busy     (rx_busy)
    );

    always #5 clock = ~clock;
    always #(os_half_ns) os_clk = ~os_clk;

    // Observe pulses away from the active edge.
    always @(negedge clock) begin
        if (data_valid) begin
            got_q.push_back(data_out);
            if (rx_busy) busy_viol++;
        end
        if (frame_error) fe_cnt++;
        if (data_valid && frame_error) both_cnt++;
        if ((data_valid && prev_valid) || (frame_error && prev_fe)) long_pulse++;
        prev_valid = data_valid;
        prev_fe    = frame_error;
    end

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        fe_cnt    = 0;
        busy_viol = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        Rx_in = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            Rx_in = b[i];
            #(BIT_NS);
        end
        Rx_in = stop_bit;
        #(BIT_NS);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (data_out !== 8'h00 || data_valid !== 1'b0 || frame_error !== 1'b0 || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got out=%h v=%b fe=%b busy=%b exp 00 0 0 0",
                     data_out, data_valid, frame_error, rx_busy);
        end
        resetn = 1'b1;
        repeat (20) @(negedge clock);
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy got %b exp 0", rx_busy);
        end
    endtask

    task automatic test_single();
        clear_obs();
        send_frame(8'hA5, 1'b1);
        exp_q.push_back(8'hA5);
        last_good = 8'hA5;
        #(BIT_NS);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
            errors++;
            $display("FAIL single_frame got %0d pulses first=%h exp 1 pulse a5", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 8'hxx);
        end
        checks++;
        if (fe_cnt != 0 || busy_viol != 0) begin
            errors++;
            $display("FAIL single_flags fe=%0d busy_at_valid=%0d exp 0 0", fe_cnt, busy_viol);
        end
        checks++;
        if (data_out !== last_good) begin
            errors++;
            $display("FAIL single_hold got %h exp %h", data_out, last_good);
        end
    endtask

    task automatic test_false_start();
        clear_obs();
        Rx_in = 1'b0;
        #(6.0 * OS_HALF_NOM);
        Rx_in = 1'b1;
        #(BIT_NS);
        checks++;
        if (got_q.size() != 0 || fe_cnt != 0 || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL false_start pulses=%0d fe=%0d busy=%b exp 0 0 0", got_q.size(), fe_cnt, rx_busy);
        end
        send_frame(8'h5A, 1'b1);
        last_good = 8'h5A;
        #(BIT_NS);
        checks++;
        if (got_q.size() != 1 || data_out !== 8'h5A) begin
            errors++;
            $display("FAIL after_false_start pulses=%0d out=%h exp 1 5a", got_q.size(), data_out);
        end
    endtask

    task automatic test_frame_error();
        clear_obs();
        send_frame(8'h3C, 1'b0);
        #(BIT_NS / 2.0);
        checks++;
        if (fe_cnt != 1 || rx_busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_err_pulse fe=%0d busy=%b exp 1 1", fe_cnt, rx_busy);
        end
        #(BIT_NS / 2.0);
        Rx_in = 1'b1;
        #(BIT_NS);
        checks++;
        if (rx_busy !== 1'b0 || fe_cnt != 1 || got_q.size() != 0) begin
            errors++;
            $display("FAIL break_release busy=%b fe=%0d pulses=%0d exp 0 1 0", rx_busy, fe_cnt, got_q.size());
        end
        checks++;
        if (data_out !== last_good) begin
            errors++;
            $display("FAIL frame_err_hold got %h exp %h", data_out, last_good);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [3];
        seq[0] = 8'h00;
        seq[1] = 8'hFF;
        seq[2] = 8'h81;
        clear_obs();
        for (int i = 0; i < 3; i++) begin
            send_frame(seq[i], 1'b1);
            exp_q.push_back(seq[i]);
        end
        last_good = 8'h81;
        #(BIT_NS);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_byte%0d got %h exp %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'hC3;
        clear_obs();
        Rx_in = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            Rx_in = b[i];
            #(BIT_NS);
        end
        Rx_in = b[4];
        #(BIT_NS / 2.0);
        @(negedge clock);
        checks++;
        if (rx_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_mid_frame got %b exp 1", rx_busy);
        end
        // Link partner resets with us, so the line returns to idle.
        resetn = 1'b0;
        Rx_in  = 1'b1;
        @(negedge clock);
        checks++;
        if (data_out !== 8'h00 || data_valid !== 1'b0 || frame_error !== 1'b0 || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_values got out=%h v=%b fe=%b busy=%b exp 00 0 0 0",
                     data_out, data_valid, frame_error, rx_busy);
        end
        @(negedge clock);
        resetn    = 1'b1;
        last_good = 8'h00;
        #(2.0 * BIT_NS);
        checks++;
        if (got_q.size() != 0 || fe_cnt != 0 || rx_busy !== 1'b0 || data_out !== last_good) begin
            errors++;
            $display("FAIL reset_mid_quiet pulses=%0d fe=%0d busy=%b out=%h exp 0 0 0 00",
                     got_q.size(), fe_cnt, rx_busy, data_out);
        end
        send_frame(8'h7E, 1'b1);
        last_good = 8'h7E;
        #(BIT_NS);
        checks++;
        if (got_q.size() != 1 || data_out !== 8'h7E) begin
            errors++;
            $display("FAIL after_reset_frame pulses=%0d out=%h exp 1 7e", got_q.size(), data_out);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int unsigned gap;
        clear_obs();
        for (int n = 0; n < 8; n++) begin
            b   = 8'($urandom);
            gap = $urandom_range(0, 2);
            send_frame(b, 1'b1);
            exp_q.push_back(b);
            last_good = b;
            #(BIT_NS * gap);
        end
        #(BIT_NS);
        checks++;
        if (got_q.size() != exp_q.size() || fe_cnt != 0) begin
            errors++;
            $display("FAIL rand_count got %0d fe=%0d exp %0d fe=0", got_q.size(), fe_cnt, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand_byte%0d got %h exp %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (data_out !== last_good) begin
            errors++;
            $display("FAIL rand_hold got %h exp %h", data_out, last_good);
        end
    endtask

    task automatic test_skew();
        real scale [2];
        scale[0] = 1.03;
        scale[1] = 0.97;
        clear_obs();
        for (int s = 0; s < 2; s++) begin
            os_half_ns = OS_HALF_NOM / scale[s];
            #(BIT_NS);
            for (int n = 0; n < 3; n++) begin
                send_frame(8'h55, 1'b1);
                exp_q.push_back(8'h55);
                #(BIT_NS);
            end
        end
        os_half_ns = OS_HALF_NOM;
        last_good  = 8'h55;
        checks++;
        if (got_q.size() != exp_q.size() || fe_cnt != 0) begin
            errors++;
            $display("FAIL skew_count got %0d fe=%0d exp %0d fe=0", got_q.size(), fe_cnt, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL skew_byte%0d got %h exp %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_pulse_rules();
        checks++;
        if (both_cnt != 0 || long_pulse != 0) begin
            errors++;
            $display("FAIL pulse_shape both=%0d long=%0d exp 0 0", both_cnt, long_pulse);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_false_start();
        test_frame_error();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_skew();
        test_pulse_rules();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
